// File: rtl/cache_arb_pkg.sv
// Shared constants and types for the 5-input cache read-data port arbiter.
package cache_arb_pkg;

  localparam int unsigned N_REQ = 5;
  localparam int unsigned SEL_W = 3;
  // Mux select code that drives zero onto the datapath.
  localparam logic [SEL_W-1:0] SEL_IDLE = 3'd7;

  typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotate-priority picker: the requester after last_win ranks highest.
module rr_pick5
  import cache_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_win,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  // Scan last_win+1, +2, .. mod N_REQ; the previous winner is checked last.
  always_comb begin
    int unsigned idx;
    logic [SEL_W-1:0] idx_s;
    any   = 1'b0;
    win   = '0;
    idx   = 0;
    idx_s = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx   = (32'(last_win) + k) % N_REQ;
      idx_s = SEL_W'(idx);
      if (!any && req[idx_s]) begin
        any = 1'b1;
        win = idx_s;
      end
    end
  end

endmodule

// File: rtl/cache_port_arb5.sv
// Round-robin burst arbiter sharing one cache port among five requesters.
// A grant is held for the whole burst, followed by one mandatory idle cycle.
module cache_port_arb5
  import cache_arb_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic                   beat_ready,
  output logic [N_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]       sel,
  output logic                   sel_valid,
  output logic                   last,
  output logic                   abort
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_win_q, last_win_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             owner_req;
  logic             beat;

  rr_pick5 u_pick (
    .req      (req),
    .last_win (last_win_q),
    .any      (pick_any),
    .win      (pick_win)
  );

  // Beat qualification and burst-end / drop detection for the current owner.
  always_comb begin
    // gnt_q is zero outside BUSY, so this is req[owner] without indexing by SEL_IDLE.
    owner_req = |(req & gnt_q);
    sel_valid = (state_q == BUSY) && owner_req;
    abort     = (state_q == BUSY) && !owner_req;
    beat      = sel_valid && beat_ready;
    last      = beat && (cnt_q == '0);
  end

  // Next-state: grant on pick in IDLE, count beats in BUSY, release on last or drop.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    last_win_d = last_win_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = BUSY;
          gnt_d      = N_REQ'(1) << pick_win;
          sel_d      = pick_win;
          cnt_d      = req_len[32'(pick_win)*LEN_W +: LEN_W];
          last_win_d = pick_win;
        end
      end
      BUSY: begin
        if (abort || last) begin
          // Drop takes priority; a beat offered in the same cycle is not counted.
          state_d = IDLE;
          gnt_d   = '0;
          sel_d   = SEL_IDLE;
          cnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
    endcase
  end

  // State registers; last_win resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= SEL_IDLE;
      cnt_q      <= '0;
      last_win_q <= SEL_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      last_win_q <= last_win_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule
